sn_wt_loader: RTL and testbench
===============================

# sn_wt_loader

Neuron-memory configuration loader between the IO manager's software register interface and the per-neuron weight/parameter memories. It accepts byte-wide commands, assembles memory words, auto-increments the neuron/register address, and buffers the writes in a small FIFO. It drains one write per cycle onto the shared `m_we`/`m_waddr`/`m_wdata` bus, and never writes while the network is executing.

## Interface
- `P_NUM_NEURONS`, 100: neuron count; valid neuron index is 1..P_NUM_NEURONS, 0 is reserved.
- `P_NUM_REGS`, 42: registers per neuron; valid register index is 0..P_NUM_REGS-1.
- `P_NEUR_MEM_ADDR_MSB_BW`, $clog2(P_NUM_NEURONS+1): width of the neuron-index field.
- `P_NEUR_MEM_ADDR_LSB_BW`, $clog2(P_NUM_REGS): width of the register-index field.
- `P_NEUR_MEM_DATA_BW`, 10: memory word width, 1..16.
- `P_FIFO_DEPTH`, 8: write-buffer entries, power of 2, ≥2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous reset, active-low.
- `cmd_vld` in 1: command valid.
- `cmd_rdy` out 1: command accepted when `cmd_vld & cmd_rdy`.
- `cmd_op` in 2: 0=SET_NEUR, 1=SET_REG, 2=DATA_LO, 3=DATA_HI_COMMIT.
- `cmd_data` in 8: command payload.
- `net_busy` in 1: network executing; no memory writes are issued while high.
- `err_clr` in 1: clears `ld_err`.
- `m_we` out 1: memory write strobe.
- `m_waddr` out MSB_BW+LSB_BW: {neuron index, register index}.
- `m_wdata` out DATA_BW: write data, LSB-aligned.
- `ld_idle` out 1: FIFO empty and no write in flight.
- `ld_err` out 1: sticky illegal-command flag.
- `ld_cnt` out $clog2(P_FIFO_DEPTH+1): FIFO occupancy.

## Operation
- Address pointer: `cur_neur`, reset value 1; `cur_reg`, reset value 0.
- SET_NEUR:
  - Payload 1..P_NUM_NEURONS: loaded into `cur_neur`, and `cur_reg` is cleared to 0.
  - Any other payload: `ld_err` is set and the pointer is unchanged.
- SET_REG:
  - Payload < P_NUM_REGS: loaded into `cur_reg`.
  - Otherwise: `ld_err` is set and the pointer is unchanged.
- DATA_LO: latches the byte into `lo_byte` and sets `lo_vld`.
- DATA_HI_COMMIT:
  - Word = {cmd_data, lo_byte} truncated to DATA_BW. If `lo_vld`=0, `lo_byte` reads as 0.
  - Pushes {cur_neur, cur_reg, word} into the FIFO and clears `lo_vld`.
  - Auto-increment: `cur_reg`+1. At P_NUM_REGS-1 it wraps to 0 and `cur_neur`+1; `cur_neur` wraps from P_NUM_NEURONS to 1.
- `cmd_rdy` = !fifo_full. This is conservative: no same-cycle push/pop at full.
- Drain FSM:
  - IDLE: FIFO empty. Moves to WRITE when the FIFO is non-empty and `net_busy`=0, or to HOLD when the FIFO is non-empty and `net_busy`=1.
  - WRITE: pops one entry per cycle. Moves to HOLD if `net_busy`=1, or to IDLE when the last entry pops.
  - HOLD: no pops. Returns to WRITE when `net_busy`=0.
- `ld_err`: set by an illegal SET_*; cleared by `err_clr`. Set wins over clear in the same cycle.

## Timing
- Reset values: `cmd_rdy`=1 (the FIFO is empty, so the `!fifo_full` rule already yields 1); `m_we`=0, `m_waddr`=0, `m_wdata`=0, `ld_idle`=1, `ld_err`=0, `ld_cnt`=0. The FIFO is emptied, `lo_vld`=0, and the FSM is in IDLE.
- All outputs are registered.
- Commit accepted at cycle N with an empty FIFO and `net_busy`=0 gives `m_we`=1 at N+2: push at N, pop decision at N+1, registered strobe at N+2.
- `net_busy` is sampled each cycle. If it is high in cycle K, there is no pop in K and `m_we`=0 in K+1. A strobe already registered in K still completes.
- Back-to-back commits sustain one `m_we` per cycle.
- `ld_idle` goes high the cycle after the final `m_we` deasserts.
- Reset asserted mid-burst: pending entries are discarded and no further `m_we` is issued.

## Configuration
- `SN_WT_LOADER_CHKSUM_EN` defined:
  - Adds output `ld_chksum` (16 bits), reset value 0.
  - On each issued write, `ld_chksum` = (`ld_chksum` + {m_waddr, m_wdata} folded to 16 bits by XOR of 16-bit slices) mod 2^16.
  - `err_clr` also clears it.
- Undefined: the port and logic are absent, and behaviour is otherwise identical.

## Structure
- The shared package `sn_pkg` holds:
  - typedef `sn_ld_op_e` (the 2-bit op enum);
  - typedef `sn_ld_entry_t` (the packed {neur, reg, data} struct);
  - typedef `sn_ld_state_e` (IDLE/WRITE/HOLD).
- Sub-module `sn_sync_fifo`: parameterised width/depth, single clock, push/pop/full/empty/count.

## Test plan
- SET_NEUR 5, SET_REG 3, DATA_LO 0x2A, DATA_HI_COMMIT 0x01 (DATA_BW=10) → single `m_we` with `m_waddr`={5,3} and `m_wdata`=0x12A at N+2.
- SET_NEUR 7, SET_REG 41, then two commits → writes to {7,41} then {8,0}. SET_NEUR 100, SET_REG 41, one commit → next pointer is {1,0}.
- SET_NEUR 0, SET_NEUR 101, SET_REG 42 → `ld_err`=1 and no FIFO push. `err_clr` → `ld_err`=0.
- `net_busy`=1 with 9 commits attempted → `cmd_rdy` drops after 8, `ld_cnt`=8, and no `m_we`. Release `net_busy` → 8 consecutive `m_we` pulses, then `ld_idle`=1.
- Toggle `net_busy` mid-drain → no `m_we` in any cycle following a busy-high cycle; order is preserved and no entries are lost.
- Assert `rst` low with 4 entries queued → all outputs take their reset values immediately and no writes follow release.

Source files
------------

// File: rtl/sn_pkg.sv
// rtl/sn_pkg.sv - shared types for the neuron-memory weight loader
package sn_pkg;

  localparam int SN_LD_NUM_NEURONS = 100;
  localparam int SN_LD_NUM_REGS    = 42;
  localparam int SN_LD_NEUR_BW     = $clog2(SN_LD_NUM_NEURONS + 1);
  localparam int SN_LD_REG_BW      = $clog2(SN_LD_NUM_REGS);
  localparam int SN_LD_DATA_BW     = 10;

  typedef enum logic [1:0] {
    SN_LD_SET_NEUR       = 2'd0,
    SN_LD_SET_REG        = 2'd1,
    SN_LD_DATA_LO        = 2'd2,
    SN_LD_DATA_HI_COMMIT = 2'd3
  } sn_ld_op_e;

  // One queued memory write; field widths follow the package constants above.
  typedef struct packed {
    logic [SN_LD_NEUR_BW-1:0] neur;
    logic [SN_LD_REG_BW-1:0]  regi;
    logic [SN_LD_DATA_BW-1:0] data;
  } sn_ld_entry_t;

  typedef enum logic [1:0] {
    SN_LD_IDLE  = 2'd0,
    SN_LD_WRITE = 2'd1,
    SN_LD_HOLD  = 2'd2
  } sn_ld_state_e;

endpackage

// File: rtl/sn_sync_fifo.sv
// rtl/sn_sync_fifo.sv - single-clock FIFO with occupancy count, first-word fall-through read
module sn_sync_fifo #(
  parameter int P_WIDTH = 8,
  parameter int P_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [P_WIDTH-1:0]           push_data,
  input  logic                         pop,
  output logic [P_WIDTH-1:0]           pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(P_DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = $clog2(P_DEPTH + 1);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == CW'(P_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage array needs no reset; only written entries are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sn_wt_loader.sv
// rtl/sn_wt_loader.sv - byte command loader for neuron memories; SN_WT_LOADER_CHKSUM_EN adds ld_chksum
module sn_wt_loader
  import sn_pkg::*;
#(
  parameter int P_NUM_NEURONS          = SN_LD_NUM_NEURONS,
  parameter int P_NUM_REGS             = SN_LD_NUM_REGS,
  parameter int P_NEUR_MEM_ADDR_MSB_BW = $clog2(P_NUM_NEURONS + 1),
  parameter int P_NEUR_MEM_ADDR_LSB_BW = $clog2(P_NUM_REGS),
  parameter int P_NEUR_MEM_DATA_BW     = SN_LD_DATA_BW,
  parameter int P_FIFO_DEPTH           = 8
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   cmd_vld,
  output logic                                                   cmd_rdy,
  input  logic [1:0]                                             cmd_op,
  input  logic [7:0]                                             cmd_data,
  input  logic                                                   net_busy,
  input  logic                                                   err_clr,
  output logic                                                   m_we,
  output logic [P_NEUR_MEM_ADDR_MSB_BW+P_NEUR_MEM_ADDR_LSB_BW-1:0] m_waddr,
  output logic [P_NEUR_MEM_DATA_BW-1:0]                          m_wdata,
  output logic                                                   ld_idle,
  output logic                                                   ld_err,
`ifdef SN_WT_LOADER_CHKSUM_EN
  output logic [15:0]                                            ld_chksum,
`endif
  output logic [$clog2(P_FIFO_DEPTH+1)-1:0]                      ld_cnt
);

  localparam int NB = P_NEUR_MEM_ADDR_MSB_BW;
  localparam int RB = P_NEUR_MEM_ADDR_LSB_BW;
  localparam int DB = P_NEUR_MEM_DATA_BW;
  localparam int CW = $clog2(P_FIFO_DEPTH + 1);
  localparam logic [7:0]    NEUR_MAX   = 8'(P_NUM_NEURONS);
  localparam logic [7:0]    REG_NUM    = 8'(P_NUM_REGS);
  localparam logic [NB-1:0] NEUR_LAST  = NB'(P_NUM_NEURONS);
  localparam logic [NB-1:0] NEUR_FIRST = NB'(1);
  localparam logic [RB-1:0] REG_LAST   = RB'(P_NUM_REGS - 1);
  localparam logic [RB-1:0] REG_ONE    = RB'(1);

  sn_ld_op_e    op;
  sn_ld_state_e state, state_nxt;
  sn_ld_entry_t push_entry, pop_entry;
  logic [NB-1:0] cur_neur;
  logic [RB-1:0] cur_reg;
  logic [7:0]    lo_byte;
  logic          lo_vld;
  logic          accept, push, pop, bad_cmd;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt, cnt_nxt;
  logic [NB+RB-1:0] wr_addr;
  logic [DB-1:0]    wr_data;

  assign op      = sn_ld_op_e'(cmd_op);
  assign accept  = cmd_vld & cmd_rdy;
  assign push    = accept & (op == SN_LD_DATA_HI_COMMIT);
  assign bad_cmd = accept & (((op == SN_LD_SET_NEUR) & ((cmd_data == 8'd0) | (cmd_data > NEUR_MAX))) |
                             ((op == SN_LD_SET_REG) & (cmd_data >= REG_NUM)));
  assign cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);
  assign ld_cnt  = fifo_cnt;

  assign push_entry.neur = SN_LD_NEUR_BW'(cur_neur);
  assign push_entry.regi = SN_LD_REG_BW'(cur_reg);
  assign push_entry.data = SN_LD_DATA_BW'({cmd_data, (lo_vld ? lo_byte : 8'd0)});
  assign wr_addr = {NB'(pop_entry.neur), RB'(pop_entry.regi)};
  assign wr_data = DB'(pop_entry.data);

  sn_sync_fifo #(
    .P_WIDTH ($bits(sn_ld_entry_t)),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // Address pointer and low-byte staging; illegal SET_* leave the pointer alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_neur <= NEUR_FIRST;
      cur_reg  <= '0;
      lo_byte  <= '0;
      lo_vld   <= 1'b0;
    end else if (accept) begin
      case (op)
        SN_LD_SET_NEUR: if (!bad_cmd) begin
          cur_neur <= NB'(cmd_data);
          cur_reg  <= '0;
        end
        SN_LD_SET_REG: if (!bad_cmd) cur_reg <= RB'(cmd_data);
        SN_LD_DATA_LO: begin
          lo_byte <= cmd_data;
          lo_vld  <= 1'b1;
        end
        default: begin
          lo_vld <= 1'b0;
          if (cur_reg == REG_LAST) begin
            cur_reg  <= '0;
            cur_neur <= (cur_neur == NEUR_LAST) ? NEUR_FIRST : cur_neur + NEUR_FIRST;
          end else begin
            cur_reg <= cur_reg + REG_ONE;
          end
        end
      endcase
    end
  end

  // Sticky error flag; a new illegal command beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ld_err <= 1'b0;
    else if (bad_cmd) ld_err <= 1'b1;
    else if (err_clr) ld_err <= 1'b0;
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SN_LD_IDLE;
    else      state <= state_nxt;
  end

  // Drain decision: pop only when the network is not running and not holding.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      SN_LD_IDLE: if (!fifo_empty) begin
        if (net_busy) state_nxt = SN_LD_HOLD;
        else begin
          pop       = 1'b1;
          state_nxt = SN_LD_WRITE;
        end
      end
      SN_LD_WRITE: begin
        if (net_busy)        state_nxt = SN_LD_HOLD;
        else if (fifo_empty) state_nxt = SN_LD_IDLE;
        else begin
          pop = 1'b1;
          if (fifo_cnt == CW'(1) && !push) state_nxt = SN_LD_IDLE;
        end
      end
      SN_LD_HOLD: if (!net_busy) state_nxt = fifo_empty ? SN_LD_IDLE : SN_LD_WRITE;
      default: state_nxt = SN_LD_IDLE;
    endcase
  end

  // Registered write bus and status; idle waits until the last strobe has dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_we    <= 1'b0;
      m_waddr <= '0;
      m_wdata <= '0;
      ld_idle <= 1'b1;
      cmd_rdy <= 1'b1;
    end else begin
      m_we <= pop;
      if (pop) begin
        m_waddr <= wr_addr;
        m_wdata <= wr_data;
      end
      ld_idle <= (cnt_nxt == '0) & ~pop & ~m_we;
      cmd_rdy <= (cnt_nxt != CW'(P_FIFO_DEPTH));
    end
  end

`ifdef SN_WT_LOADER_CHKSUM_EN
  localparam int FW = ((NB + RB + DB + 15) / 16) * 16;

  function automatic logic [15:0] fold16(input logic [FW-1:0] v);
    logic [15:0] f;
    f = '0;
    for (int i = 0; i < FW / 16; i++) f = f ^ v[i*16 +: 16];
    return f;
  endfunction

  // Running sum of every issued write, folded to 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ld_chksum <= '0;
    else if (err_clr) ld_chksum <= '0;
    else if (pop)     ld_chksum <= ld_chksum + fold16(FW'({wr_addr, wr_data}));
  end
`endif

endmodule

// File: tb/tb_sn_wt_loader.sv
// tb/tb_sn_wt_loader.sv - self-checking bench for sn_wt_loader
module tb_sn_wt_loader;

  localparam int NN    = 100;
  localparam int NR    = 42;
  localparam int MSB   = $clog2(NN + 1);
  localparam int LSB   = $clog2(NR);
  localparam int DW    = 10;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = MSB + LSB;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_vld, cmd_rdy, net_busy, err_clr;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_data;
  logic          m_we, ld_idle, ld_err;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [CW-1:0] ld_cnt;
`ifdef SN_WT_LOADER_CHKSUM_EN
  logic [15:0]   ld_chksum;
  logic [15:0]   m_chk;
`endif

  sn_wt_loader dut (
    .clk (clk), .rst (rst), .cmd_vld (cmd_vld), .cmd_rdy (cmd_rdy),
    .cmd_op (cmd_op), .cmd_data (cmd_data), .net_busy (net_busy), .err_clr (err_clr),
    .m_we (m_we), .m_waddr (m_waddr), .m_wdata (m_wdata), .ld_idle (ld_idle),
    .ld_err (ld_err),
`ifdef SN_WT_LOADER_CHKSUM_EN
    .ld_chksum (ld_chksum),
`endif
    .ld_cnt (ld_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  m_lin;
  int  m_lo;
  bit  m_lo_vld;
  bit  m_err;
  bit  rand_busy = 1'b0;
  bit  prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lin = 0; m_lo = 0; m_lo_vld = 1'b0; m_err = 1'b0;
    exp_q.delete();
`ifdef SN_WT_LOADER_CHKSUM_EN
    m_chk = '0;
`endif
  endtask

  // Pointer kept as a linear index over all (neuron, register) slots.
  task automatic model_apply(input int op, input int d);
    wr_t e;
    int  word;
    case (op)
      0: if (d >= 1 && d <= NN) m_lin = (d - 1) * NR; else m_err = 1'b1;
      1: if (d < NR) m_lin = (m_lin / NR) * NR + d; else m_err = 1'b1;
      2: begin m_lo = d; m_lo_vld = 1'b1; end
      default: begin
        word   = ((d * 256) + (m_lo_vld ? m_lo : 0)) % (1 << DW);
        e.addr = AW'(((m_lin / NR) + 1) * (1 << LSB) + (m_lin % NR));
        e.data = DW'(word);
        exp_q.push_back(e);
        m_lo_vld = 1'b0;
        m_lin    = (m_lin + 1) % (NN * NR);
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_busy) net_busy = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send(input int op, input int d);
    int w;
    cmd_op = 2'(op); cmd_data = 8'(d); cmd_vld = 1'b1;
    w = 0;
    while (!cmd_rdy && w < 300) begin tick(); w++; end
    if (w >= 300) begin
      chk("send_timeout", 32'd0, 32'd1);
      cmd_vld = 1'b0;
      return;
    end
    tick();
    cmd_vld = 1'b0;
    model_apply(op, d);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    m_err = 1'b0;
`ifdef SN_WT_LOADER_CHKSUM_EN
    m_chk = '0;
`endif
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !ld_idle) && w < 400) begin tick(); w++; end
    chk(tag, {31'd0, (exp_q.size() == 0 && ld_idle === 1'b1)}, 32'd1);
  endtask

  // Busy level the DUT saw in the cycle that just ended.
  always @(posedge clk) prev_busy = net_busy;

  // Write monitor: order, content, and no strobe after a busy cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && m_we === 1'b1) begin
      chk("we_after_busy", {31'd0, prev_busy}, 32'd0);
      if (exp_q.size() == 0) chk("unexpected_write", {19'd0, m_waddr}, 32'hFFFF_FFFF);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", {19'd0, m_waddr}, {19'd0, e.addr});
        chk("write_data", {22'd0, m_wdata}, {22'd0, e.data});
`ifdef SN_WT_LOADER_CHKSUM_EN
        m_chk = m_chk + 16'((({e.addr, e.data} & 32'hFFFF) ^ ({9'd0, e.addr, e.data} >> 16)));
`endif
      end
    end
  end

  initial begin
    int n;
    int pulses;
    rst = 1'b0; cmd_vld = 1'b0; cmd_op = '0; cmd_data = '0; net_busy = 1'b0; err_clr = 1'b0;
    model_reset();
    #12;
    chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_m_waddr", {19'd0, m_waddr}, 32'd0);
    chk("rst_m_wdata", {22'd0, m_wdata}, 32'd0);
    chk("rst_ld_idle", {31'd0, ld_idle}, 32'd1);
    chk("rst_ld_err", {31'd0, ld_err}, 32'd0);
    chk("rst_ld_cnt", {28'd0, ld_cnt}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    tick(); tick();

    // Basic write and N+2 latency.
    send(0, 5); send(1, 3); send(2, 'h2A); send(3, 'h01);
    chk("t1_n1_we", {31'd0, m_we}, 32'd0);
    chk("t1_n1_idle", {31'd0, ld_idle}, 32'd0);
    tick();
    chk("t1_n2_we", {31'd0, m_we}, 32'd1);
    chk("t1_n2_addr", {19'd0, m_waddr}, (32'd5 << LSB) | 32'd3);
    chk("t1_n2_data", {22'd0, m_wdata}, 32'h12A);
    drain("t1_drain");

    // Register and neuron wrap.
    send(0, 7); send(1, 41); send(2, $urandom_range(0, 255));
    send(3, $urandom_range(0, 255)); send(3, $urandom_range(0, 255));
    send(0, 100); send(1, 41); send(3, $urandom_range(0, 255)); send(3, $urandom_range(0, 255));
    drain("t2_drain");

    // Illegal SET_* commands.
    send(0, 0);
    chk("t3_err_neur0", {31'd0, ld_err}, 32'd1);
    pulse_clr();
    chk("t3_clr", {31'd0, ld_err}, 32'd0);
    send(0, 101); send(1, 42);
    chk("t3_err_set", {31'd0, ld_err}, 32'd1);
    chk("t3_no_push", {28'd0, ld_cnt}, 32'd0);
    pulse_clr();
    chk("t3_clr2", {31'd0, ld_err}, 32'd0);
    send(3, $urandom_range(0, 255));
    drain("t3_drain");

    // Fill while busy, then release.
    net_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) send(3, $urandom_range(0, 255));
    chk("t4_cnt_full", {28'd0, ld_cnt}, DEPTH);
    chk("t4_rdy_low", {31'd0, cmd_rdy}, 32'd0);
    cmd_op = 2'd3; cmd_data = 8'h55; cmd_vld = 1'b1;
    tick(); tick(); tick();
    cmd_vld = 1'b0;
    chk("t4_ninth_blocked", {28'd0, ld_cnt}, DEPTH);
    chk("t4_idle_low", {31'd0, ld_idle}, 32'd0);
    net_busy = 1'b0;
    n = 0;
    while (m_we !== 1'b1 && n < 10) begin tick(); n++; end
    pulses = 0;
    while (m_we === 1'b1 && pulses < 20) begin pulses++; tick(); end
    chk("t4_burst_len", pulses, DEPTH);
    drain("t4_idle");

    // Busy toggled mid-drain.
    net_busy = 1'b1;
    for (int i = 0; i < 6; i++) send(3, $urandom_range(0, 255));
    for (int i = 0; i < 24; i++) begin
      net_busy = (i % 3 == 0);
      tick();
    end
    net_busy = 1'b0;
    drain("t5_drain");

    // Randomised command stream with random busy.
    rand_busy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op == 0)      send(0, $urandom_range(0, 110));
      else if (op == 1) send(1, $urandom_range(0, 45));
      else if (op < 5)  send(2, $urandom_range(0, 255));
      else              send(3, $urandom_range(0, 255));
    end
    rand_busy = 1'b0;
    net_busy  = 1'b0;
    drain("t6_drain");
    chk("t6_err", {31'd0, ld_err}, {31'd0, m_err});
`ifdef SN_WT_LOADER_CHKSUM_EN
    chk("t6_chksum", {16'd0, ld_chksum}, {16'd0, m_chk});
`endif
    pulse_clr();

    // Reset with entries queued.
    net_busy = 1'b1;
    send(0, 0);
    for (int i = 0; i < 4; i++) send(3, $urandom_range(0, 255));
    chk("t7_cnt_pre", {28'd0, ld_cnt}, 32'd4);
    #3 rst = 1'b0;
    #1;
    chk("t7_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("t7_we", {31'd0, m_we}, 32'd0);
    chk("t7_addr", {19'd0, m_waddr}, 32'd0);
    chk("t7_data", {22'd0, m_wdata}, 32'd0);
    chk("t7_idle", {31'd0, ld_idle}, 32'd1);
    chk("t7_err", {31'd0, ld_err}, 32'd0);
    chk("t7_cnt", {28'd0, ld_cnt}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    net_busy = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t7_post_cnt", {28'd0, ld_cnt}, 32'd0);
    chk("t7_post_idle", {31'd0, ld_idle}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
